// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and the
// architectural constants it matches against.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [31:0] HALT_INSN_DEF = 32'hFFFF_FFFF;
    localparam logic [4:0]  REG_ZERO      = 5'd0;

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// cycle and stall performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: stall/bubble/flush decode for load-use and taken
// branches, halt detection with a fixed-length drain, and perf counters.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSN    = HALT_INSN_DEF,
    parameter int          DRAIN_CYCLES = 3,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             end_program,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output state_t           state_dbg
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state, next_state;
    logic [DW-1:0] drain_cnt, drain_next;
    logic          lu_stall, halt_det, stall_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            end_program <= 1'b0;
        end else begin
            state       <= next_state;
            drain_cnt   <= drain_next;
            end_program <= (next_state == ST_HALTED);
        end
    end

    always_comb begin
        next_state  = state;
        drain_next  = drain_cnt;
        stall_inc   = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
        lu_stall    = id_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
        halt_det    = id_valid && (id_instr == HALT_INSN) && !ex_branch_taken;

        case (state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                end else if (halt_det) begin
                    next_state = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (lu_stall) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_flush = 1'b0;
                end
            end
            // EX only ever sees bubbles here, so a branch input is ignored.
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = ST_HALTED;
                end else begin
                    drain_next = drain_cnt - DW'(1);
                end
            end
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_RUN;
        endcase

        // Hold the pipeline frozen and bubbled for as long as reset is low.
        if (!reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign state_dbg = state;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state != ST_HALTED),
        .clr   (1'b0),
        .count (cycle_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_inc),
        .clr   (1'b0),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: reset, load-use, x0, branch
// priority, halt/drain timing and reset during drain/halted.
module tb_pipeline_control_unit;
    import pipeline_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic [31:0] id_instr;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, end_program;
    logic [31:0] cycle_count, stall_count;
    state_t      state_dbg;
    logic [3:0]  outs;
    int          total = 0;
    int          bad = 0;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush};

    pipeline_control_unit #(.HALT_INSN(32'hFFFF_FFFF), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .end_program(end_program),
        .cycle_count(cycle_count), .stall_count(stall_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // EX holds only bubbles while draining, so no redirect may arrive then.
    always @(posedge clk) begin
        if (reset && state_dbg == ST_DRAIN)
            assert (!ex_branch_taken) else $error("branch taken during DRAIN");
    end

    task automatic idle_inputs();
        id_valid = 0; id_instr = 32'h0000_0013; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
    endtask

    // Returns at a falling edge with reset just released: cycle_count is 0.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 0;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic set_load_use();
        id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        @(negedge clk); #1;
        total++; if (outs !== 4'b0011) begin bad++; $display("FAIL rst_outs got=%b exp=0011", outs); end
        total++; if (end_program !== 1'b0) begin bad++; $display("FAIL rst_end got=%b exp=0", end_program); end
        total++; if (cycle_count !== 0 || stall_count !== 0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", cycle_count, stall_count); end
        total++; if (state_dbg !== ST_RUN) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
        @(negedge clk);
        reset = 1;
        #1;
        total++; if (outs !== 4'b1100) begin bad++; $display("FAIL run_outs got=%b exp=1100", outs); end
        @(negedge clk);
        total++; if (cycle_count !== 1) begin bad++; $display("FAIL run_cycle got=%0d exp=1", cycle_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        total++; if (outs !== 4'b0001) begin bad++; $display("FAIL lu_rs1_outs got=%b exp=0001", outs); end
        @(negedge clk);
        total++; if (stall_count !== 1) begin bad++; $display("FAIL lu_rs1_cnt got=%0d exp=1", stall_count); end
        id_uses_rs1 = 0; id_rs1 = 3; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        #1;
        total++; if (outs !== 4'b0001) begin bad++; $display("FAIL lu_rs2_outs got=%b exp=0001", outs); end
        @(negedge clk);
        total++; if (stall_count !== 2) begin bad++; $display("FAIL lu_rs2_cnt got=%0d exp=2", stall_count); end
        id_uses_rs2 = 0;
        #1;
        total++; if (outs !== 4'b1100) begin bad++; $display("FAIL lu_unused_outs got=%b exp=1100", outs); end
        id_uses_rs2 = 1; id_valid = 0;
        #1;
        total++; if (outs !== 4'b1100) begin bad++; $display("FAIL lu_novalid_outs got=%b exp=1100", outs); end
        @(negedge clk);
        total++; if (stall_count !== 2 || cycle_count !== 3) begin bad++; $display("FAIL lu_final_cnt got=%0d/%0d exp=2/3", stall_count, cycle_count); end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        do_reset();
        id_valid = 1; ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 1; id_uses_rs2 = 1;
        #1;
        total++; if (outs !== 4'b1100) begin bad++; $display("FAIL x0_outs got=%b exp=1100", outs); end
        @(negedge clk);
        total++; if (stall_count !== 0) begin bad++; $display("FAIL x0_cnt got=%0d exp=0", stall_count); end
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_load_use();
        id_instr = 32'hFFFF_FFFF; ex_branch_taken = 1;
        #1;
        total++; if (outs !== 4'b1111) begin bad++; $display("FAIL br_outs got=%b exp=1111", outs); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (state_dbg !== ST_RUN) begin bad++; $display("FAIL br_state got=%0d exp=0", state_dbg); end
        total++; if (stall_count !== 0) begin bad++; $display("FAIL br_cnt got=%0d exp=0", stall_count); end
        total++; if (outs !== 4'b1100) begin bad++; $display("FAIL br_after_outs got=%b exp=1100", outs); end
        repeat (4) @(negedge clk);
        total++; if (end_program !== 1'b0) begin bad++; $display("FAIL br_end got=%b exp=0", end_program); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (2) @(negedge clk);
        set_load_use();
        id_instr = 32'hFFFF_FFFF;
        #1;
        total++; if (outs !== 4'b0001) begin bad++; $display("FAIL halt_outs got=%b exp=0001", outs); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (state_dbg !== ST_DRAIN || end_program !== 1'b0) begin bad++; $display("FAIL drain1 got=%0d/%b exp=1/0", state_dbg, end_program); end
        total++; if (outs !== 4'b0001) begin bad++; $display("FAIL drain_outs got=%b exp=0001", outs); end
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            total++; if (state_dbg !== ST_DRAIN || end_program !== 1'b0) begin bad++; $display("FAIL drain%0d got=%0d/%b exp=1/0", i, state_dbg, end_program); end
        end
        @(negedge clk);
        total++; if (state_dbg !== ST_HALTED || end_program !== 1'b1) begin bad++; $display("FAIL halted got=%0d/%b exp=2/1", state_dbg, end_program); end
        total++; if (cycle_count !== 6 || stall_count !== 0) begin bad++; $display("FAIL halted_cnt got=%0d/%0d exp=6/0", cycle_count, stall_count); end
        set_load_use();
        repeat (3) @(negedge clk);
        total++; if (cycle_count !== 6 || stall_count !== 0) begin bad++; $display("FAIL frozen_cnt got=%0d/%0d exp=6/0", cycle_count, stall_count); end
        total++; if (outs !== 4'b0001 || end_program !== 1'b1) begin bad++; $display("FAIL halted_outs got=%b/%b exp=0001/1", outs, end_program); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        repeat (2) @(negedge clk);
        id_valid = 1; id_instr = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        total++; if (state_dbg !== ST_DRAIN) begin bad++; $display("FAIL mid_pre got=%0d exp=1", state_dbg); end
        #2 reset = 0;
        #1;
        total++; if (state_dbg !== ST_RUN || end_program !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%b exp=0/0", state_dbg, end_program); end
        total++; if (cycle_count !== 0 || stall_count !== 0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", cycle_count, stall_count); end
        total++; if (outs !== 4'b0011) begin bad++; $display("FAIL mid_rst_outs got=%b exp=0011", outs); end
        @(negedge clk);
        reset = 1;
        id_valid = 1; id_instr = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        total++; if (end_program !== 1'b0) begin bad++; $display("FAIL rehalt_n3 got=%b exp=0", end_program); end
        @(negedge clk);
        total++; if (end_program !== 1'b1 || cycle_count !== 4) begin bad++; $display("FAIL rehalt_n4 got=%b/%0d exp=1/4", end_program, cycle_count); end
        #2 reset = 0;
        #1;
        total++; if (end_program !== 1'b0 || state_dbg !== ST_RUN) begin bad++; $display("FAIL halted_rst got=%b/%0d exp=0/0", end_program, state_dbg); end
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch_priority();
        test_halt();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
